// File: rtl/core_ctrl_pkg.sv
// Shared constants for the core instruction sequencer: inst field positions,
// the idle instruction word, the sequencer state set and a fill-word helper.
package core_ctrl_pkg;

  localparam int INST_W = 36;
  localparam int ADDR_W = 11;

  // inst field bit positions
  localparam int B_RSVD       = 35;
  localparam int B_BYPASS     = 34;
  localparam int B_ACC        = 33;
  localparam int B_CEN_PMEM   = 32;
  localparam int B_WEN_PMEM   = 31;
  localparam int B_A_PMEM_HI  = 30;
  localparam int B_A_PMEM_LO  = 20;
  localparam int B_CEN_XMEM   = 19;
  localparam int B_WEN_XMEM   = 18;
  localparam int B_A_XMEM_HI  = 17;
  localparam int B_A_XMEM_LO  = 7;
  localparam int B_OFIFO_RD   = 6;
  localparam int B_IFIFO_WR   = 5;
  localparam int B_IFIFO_RD   = 4;
  localparam int B_L0_RD      = 3;
  localparam int B_L0_WR      = 2;
  localparam int B_EXECUTE    = 1;
  localparam int B_LOAD       = 0;

  // Both memories deselected and write-disabled, everything else quiet
  localparam logic [INST_W-1:0] INST_IDLE = 36'h1_800C_0000;

  // Bits this sequencer never drives high
  localparam logic [INST_W-1:0] INST_FIXED_ZERO =
      (36'd1 << B_RSVD) | (36'd1 << B_ACC) |
      (36'd1 << B_IFIFO_WR) | (36'd1 << B_IFIFO_RD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFILL,
    S_LOAD,
    S_GAP,
    S_AFILL,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_t;

  // One cycle of an xmem -> L0 streaming phase. Step c reads word c from xmem
  // while step c-1's data (already on the xmem output) is written into L0; the
  // final step (c == last) only finishes the L0 write with xmem deselected.
  function automatic logic [INST_W-1:0] fill_word(input logic [ADDR_W-1:0] base,
                                                  input logic [7:0] c,
                                                  input logic [7:0] last);
    logic [INST_W-1:0] w;
    logic [7:0]        off;
    w   = INST_IDLE;
    off = (c < last) ? c : (last - 8'd1);
    w[B_CEN_XMEM] = (c == last);
    w[B_A_XMEM_HI:B_A_XMEM_LO] = base + {3'b000, off};
    w[B_L0_WR] = (c != 8'd0);
    return w & ~INST_FIXED_ZERO;
  endfunction

endpackage

// File: rtl/core_ctrl_drain.sv
// OFIFO drain engine: issues OFIFO reads while data is available, and retires
// each read as a PMEM write RD2WR_LAT cycles later at kij*LEN_ONIJ + wr_cnt.
// Outputs describe the instruction word being loaded on the coming edge.
module core_ctrl_drain
  import core_ctrl_pkg::*;
#(
  parameter int LEN_ONIJ  = 16,
  parameter int RD2WR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              ofifo_valid,
  input  logic [3:0]        kij,
  output logic              ofifo_rd,
  output logic              pmem_wr,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              fin
);

  localparam logic [4:0]        CNT_MAX = 5'(LEN_ONIJ);
  localparam logic [ADDR_W-1:0] STRIDE  = 11'(LEN_ONIJ);

  logic [4:0]           rd_cnt_reg;
  logic [4:0]           wr_cnt_reg;
  logic [RD2WR_LAT-1:0] pend_reg;
  logic [RD2WR_LAT:0]   pend_ext;

  assign ofifo_rd  = en && ofifo_valid && (rd_cnt_reg < CNT_MAX);
  assign pmem_wr   = en && pend_reg[RD2WR_LAT-1];
  assign pmem_addr = pmem_wr ? (11'(kij) * STRIDE + 11'(wr_cnt_reg)) : '0;
  assign fin       = (wr_cnt_reg == CNT_MAX);
  assign pend_ext  = {pend_reg, ofifo_rd};

  // Read/write counters and read-to-write delay line; cleared whenever idle so
  // every pass starts from zero and nothing is left pending after an abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      pend_reg   <= '0;
    end else if (!en) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      pend_reg   <= '0;
    end else begin
      if (ofifo_rd) rd_cnt_reg <= rd_cnt_reg + 5'd1;
      if (pmem_wr && (wr_cnt_reg != CNT_MAX)) wr_cnt_reg <= wr_cnt_reg + 5'd1;
      pend_reg <= pend_ext[RD2WR_LAT-1:0];
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// Instruction sequencer for one kernel-offset pass of core: weight fill, PE
// load, gap, activation fill, execute, then OFIFO drain into PMEM.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int              ROW       = 8,
  parameter int              COL       = 8,
  parameter int              LEN_NIJ   = 36,
  parameter int              LEN_ONIJ  = 16,
  parameter int              LEN_KIJ   = 9,
  parameter logic [ADDR_W-1:0] W_BASE  = 11'h400,
  parameter int              GAP_CYC   = 11,
  parameter int              RD2WR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        kij,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] WFILL_LAST = 8'(COL);
  localparam logic [7:0] LOAD_LAST  = 8'(COL + ROW - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] AFILL_LAST = 8'(LEN_NIJ);
  localparam logic [7:0] EXEC_LAST  = 8'(ROW + COL + LEN_NIJ - 1);
  localparam logic [4:0] KIJ_LIM    = 5'(LEN_KIJ);
  localparam logic [ADDR_W-1:0] A_BASE = '0;

  localparam logic [INST_W-1:0] LOAD_WORD =
      INST_IDLE | (36'd1 << B_LOAD) | (36'd1 << B_L0_RD);
  localparam logic [INST_W-1:0] EXEC_WORD =
      INST_IDLE | (36'd1 << B_EXECUTE) | (36'd1 << B_L0_RD);

  state_t            state_reg;
  logic [7:0]        cnt_reg;
  logic [3:0]        kij_reg;

  logic              drain_en;
  logic              drain_rd;
  logic              drain_wr;
  logic              drain_fin;
  logic [ADDR_W-1:0] drain_addr;
  logic [INST_W-1:0] drain_word;

  // The drain engine runs from the edge that leaves EXEC until its last write
  assign drain_en = ((state_reg == S_EXEC) && (cnt_reg == EXEC_LAST)) ||
                    ((state_reg == S_DRAIN) && !drain_fin);

  core_ctrl_drain #(
    .LEN_ONIJ  (LEN_ONIJ),
    .RD2WR_LAT (RD2WR_LAT)
  ) u_drain (
    .clk         (clk),
    .reset       (reset),
    .en          (drain_en),
    .ofifo_valid (ofifo_valid),
    .kij         (kij_reg),
    .ofifo_rd    (drain_rd),
    .pmem_wr     (drain_wr),
    .pmem_addr   (drain_addr),
    .fin         (drain_fin)
  );

  // Drain-phase instruction word: SFU bypass, optional OFIFO read, optional PMEM write
  always_comb begin
    drain_word = INST_IDLE;
    drain_word[B_BYPASS]   = 1'b1;
    drain_word[B_OFIFO_RD] = drain_rd;
    if (drain_wr) begin
      drain_word[B_CEN_PMEM] = 1'b0;
      drain_word[B_WEN_PMEM] = 1'b0;
      drain_word[B_A_PMEM_HI:B_A_PMEM_LO] = drain_addr;
    end
    drain_word = drain_word & ~INST_FIXED_ZERO;
  end

  // Pass sequencer; inst is loaded with the word for the state/count being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      kij_reg   <= '0;
      inst      <= INST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            if ({1'b0, kij} < KIJ_LIM) begin
              state_reg <= S_WFILL;
              cnt_reg   <= '0;
              kij_reg   <= kij;
              busy      <= 1'b1;
              inst      <= fill_word(W_BASE, 8'd0, WFILL_LAST);
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WFILL: begin
          if (cnt_reg == WFILL_LAST) begin
            state_reg <= S_LOAD;
            cnt_reg   <= '0;
            inst      <= LOAD_WORD;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
            inst    <= fill_word(W_BASE, cnt_reg + 8'd1, WFILL_LAST);
          end
        end
        S_LOAD: begin
          if (cnt_reg == LOAD_LAST) begin
            state_reg <= S_GAP;
            cnt_reg   <= '0;
            inst      <= INST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            state_reg <= S_AFILL;
            cnt_reg   <= '0;
            inst      <= fill_word(A_BASE, 8'd0, AFILL_LAST);
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_AFILL: begin
          if (cnt_reg == AFILL_LAST) begin
            state_reg <= S_EXEC;
            cnt_reg   <= '0;
            inst      <= EXEC_WORD;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
            inst    <= fill_word(A_BASE, cnt_reg + 8'd1, AFILL_LAST);
          end
        end
        S_EXEC: begin
          if (cnt_reg == EXEC_LAST) begin
            state_reg <= S_DRAIN;
            cnt_reg   <= '0;
            inst      <= drain_word;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_fin) begin
            state_reg <= S_DONE;
            cnt_reg   <= '0;
            inst      <= INST_IDLE;
            done      <= 1'b1;
          end else begin
            inst <= drain_word;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          inst      <= INST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: a behavioural model builds the expected inst
// trace of a pass from phase lengths and a read/write queue, a compare process
// checks every cycle, and hand-computed literals pin key words and timings.
module tb_core_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int NIJ  = 36;
  localparam int ONIJ = 16;
  localparam int GAP  = 11;
  localparam int LAT  = 2;
  localparam int TMAX = 170;
  localparam logic [35:0] IDLE_W = 36'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  kij = 4'd0;
  logic        ofifo_valid = 1'b1;
  logic [35:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .kij         (kij),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base_cyc = 0;
  bit chk_en = 1'b0;
  int done_t = 0;

  logic [35:0] exp_inst [0:TMAX];
  bit          exp_busy [0:TMAX];
  bit          exp_done [0:TMAX];
  bit          vld      [0:TMAX+1];
  logic [35:0] obs_inst [0:TMAX];
  bit          obs_done [0:TMAX];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Streaming step c of n words from xmem starting at base_a
  function automatic logic [35:0] fillw(input int base_a, input int c, input int n);
    logic [35:0] w;
    int a;
    w = IDLE_W;
    a = base_a + ((c < n) ? c : n - 1);
    if (c != n) w[19] = 1'b0;
    w[17:7] = 11'(a);
    w[2] = (c >= 1);
    return w;
  endfunction

  // Expected trace of one pass; index t = word present after edge t (edge 0 accepts start)
  task automatic build_model(input int k);
    int t;
    int rd;
    int wr;
    int q[$];
    logic [35:0] w;
    t = 0; rd = 0; wr = 0;
    for (int c = 0; c <= COL; c++) begin exp_inst[t] = fillw(1024, c, COL); t++; end
    for (int i = 0; i < ROW + COL; i++) begin exp_inst[t] = IDLE_W | 36'h9; t++; end
    for (int i = 0; i < GAP; i++) begin exp_inst[t] = IDLE_W; t++; end
    for (int c = 0; c <= NIJ; c++) begin exp_inst[t] = fillw(0, c, NIJ); t++; end
    for (int i = 0; i < ROW + COL + NIJ; i++) begin exp_inst[t] = IDLE_W | 36'hA; t++; end
    while (wr < ONIJ && t < TMAX) begin
      w = IDLE_W;
      w[34] = 1'b1;
      if (rd < ONIJ && vld[t]) begin
        w[6] = 1'b1;
        rd++;
        q.push_back(t + LAT);
      end
      if (q.size() > 0 && q[0] == t) begin
        void'(q.pop_front());
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = 11'(k * ONIJ + wr);
        wr++;
      end
      exp_inst[t] = w;
      t++;
    end
    done_t = t;
    for (int i = 0; i <= TMAX; i++) begin
      exp_busy[i] = (i <= done_t);
      exp_done[i] = (i == done_t);
      if (i >= done_t) exp_inst[i] = IDLE_W;
    end
  endtask

  // Compare process: checks DUT against the model every cycle of a modelled pass
  always begin : compare
    int t;
    @(posedge clk);
    #1;
    if (chk_en) begin
      t = cyc - base_cyc;
      if (t >= 0 && t <= TMAX) begin
        chk($sformatf("inst t=%0d", t), 64'(inst), 64'(exp_inst[t]));
        chk($sformatf("busy t=%0d", t), 64'(busy), 64'(exp_busy[t]));
        chk($sformatf("done t=%0d", t), 64'(done), 64'(exp_done[t]));
        chk($sformatf("err t=%0d", t), 64'(err), 64'd0);
        obs_inst[t] = inst;
        obs_done[t] = done;
      end
    end
  end

  // One pass: optional ofifo_valid stall window and optional extra start pulse at edge extra_t
  task automatic run_pass(input int k, input int stall_from, input int stall_len,
                          input int extra_t, input int extra_kij);
    for (int i = 0; i <= TMAX + 1; i++)
      vld[i] = !(i >= stall_from && i < stall_from + stall_len);
    build_model(k);
    @(negedge clk);
    kij = 4'(k);
    start = 1'b1;
    ofifo_valid = vld[0];
    base_cyc = cyc + 1;
    chk_en = 1'b1;
    for (int t = 0; t <= TMAX; t++) begin
      @(posedge clk);
      #2;
      start = (t + 1 == extra_t);
      kij = start ? 4'(extra_kij) : 4'(k);
      ofifo_valid = vld[t + 1];
    end
    chk_en = 1'b0;
    start = 1'b0;
    ofifo_valid = 1'b1;
    $display("pass kij=%0d stall=%0d extra_start=%0d checks=%0d errors=%0d",
             k, stall_len, extra_t, checks, errors);
  endtask

  // Summary properties of the observed trace against hand-derived numbers
  task automatic analyze(input int k, input int exp_done_t);
    int nrd, nwr, nld, nex, nl0w, first_done;
    bit contig, byp;
    nrd = 0; nwr = 0; nld = 0; nex = 0; nl0w = 0; first_done = -1;
    contig = 1'b1; byp = 1'b1;
    for (int t = 0; t <= TMAX; t++) begin
      if (obs_inst[t][6]) nrd++;
      if (!obs_inst[t][31]) begin
        if (int'(obs_inst[t][30:20]) != k * 16 + nwr) contig = 1'b0;
        nwr++;
      end
      if (obs_inst[t][0]) nld++;
      if (obs_inst[t][1]) nex++;
      if (t <= COL && obs_inst[t][2]) nl0w++;
      if (obs_done[t] && first_done < 0) first_done = t;
    end
    for (int t = 125; t < first_done; t++)
      if (!obs_inst[t][34]) byp = 1'b0;
    chk($sformatf("reads kij=%0d", k), 64'(nrd), 64'd16);
    chk($sformatf("writes kij=%0d", k), 64'(nwr), 64'd16);
    chk($sformatf("contig kij=%0d", k), 64'(contig), 64'd1);
    chk($sformatf("bypass kij=%0d", k), 64'(byp), 64'd1);
    chk($sformatf("done_edge kij=%0d", k), 64'(first_done), 64'(exp_done_t));
    chk($sformatf("load_cycles kij=%0d", k), 64'(nld), 64'd16);
    chk($sformatf("exec_cycles kij=%0d", k), 64'(nex), 64'd52);
    chk($sformatf("l0_wr_wfill kij=%0d", k), 64'(nl0w), 64'd8);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    #12;
    chk("rst inst", 64'(inst), 64'(IDLE_W));
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // kij=0, ofifo_valid high throughout
    run_pass(0, -1, 0, -1, 0);
    analyze(0, 143);
    chk("k0 wfill first word", 64'(obs_inst[0]), 64'h0_0000_0001_8006_0000 >> 0);
    chk("k0 wfill last addr", 64'(obs_inst[7][17:7]), 64'h407);
    chk("k0 first drain word", 64'(obs_inst[125]), 64'h5_800C_0040);
    chk("k0 first write word", 64'(obs_inst[127]), 64'h4_000C_0040);

    // kij=8, top of the PMEM address range
    run_pass(8, -1, 0, -1, 0);
    analyze(8, 143);
    chk("k8 first write word", 64'(obs_inst[127]), 64'h4_080C_0040);
    chk("k8 last write word", 64'(obs_inst[142]), 64'h4_08FC_0000);

    // kij=9 is out of range: one err pulse, nothing else moves
    @(negedge clk);
    kij = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("k9 err", 64'(err), 64'd1);
    chk("k9 busy", 64'(busy), 64'd0);
    chk("k9 inst", 64'(inst), 64'(IDLE_W));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("k9 err cleared", 64'(err), 64'd0);
    chk("k9 busy after", 64'(busy), 64'd0);
    $display("reject kij=9 checks=%0d errors=%0d", checks, errors);

    // ofifo_valid low for 5 cycles mid-drain
    run_pass(2, 130, 5, -1, 0);
    analyze(2, 148);

    // start (with an illegal kij) pulsed during LOAD is ignored
    run_pass(3, -1, 0, 12, 12);
    analyze(3, 143);

    // Reset asserted mid-EXEC
    @(negedge clk);
    kij = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (90) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    chk("pre-reset execute", 64'(inst[1]), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst inst", 64'(inst), 64'(IDLE_W));
    chk("midrst busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst inst c=%0d", i), 64'(inst), 64'(IDLE_W));
      chk($sformatf("postrst busy c=%0d", i), 64'(busy), 64'd0);
    end
    $display("reset mid-exec checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Instruction sequencer that sits directly upstream of `core` and drives its 36-bit `inst` bus. It replaces hand-written bench stimulus for one kernel-offset pass (kij). Per pass it streams weights from xmem into L0, loads them into the PE array, streams activations into L0, executes, and drains the OFIFO through the SFU in bypass into PMEM at `kij*LEN_ONIJ`. It runs one pass per `start` and reports completion with `done`.

## Interface
- `ROW`, 8, PE array rows
- `COL`, 8, PE array columns
- `LEN_NIJ`, 36, activation words per pass
- `LEN_ONIJ`, 16, output words per pass
- `LEN_KIJ`, 9, number of valid kij values
- `W_BASE`, 11'h400, xmem base address of the weight tile
- `GAP_CYC`, 11, idle cycles between kernel load and activation fill
- `RD2WR_LAT`, 2, cycles from `ofifo_rd` in `inst` to a valid `sfp_out`
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to run a pass
- `kij`  in  4  kernel offset index, latched on an accepted `start`
- `ofifo_valid`  in  1  OFIFO non-empty, from `core`
- `inst`  out  36  core instruction word, registered
- `busy`  out  1  high from the accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse when the pass completes
- `err`  out  1  one-cycle pulse when a `start` is rejected

## Operation
- `inst` bit map:
  - [35]=0, [34] bypass, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem.
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem.
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- Idle word: CEN and WEN bits high (bits 32, 31, 19, 18), all other bits 0, so `inst` = 36'h1_800C_0000. `ififo_*` and `acc` are always 0.
- Accepting `start`:
  - `start` in IDLE with `kij < LEN_KIJ` is accepted.
  - `start` in IDLE with `kij >= LEN_KIJ` is rejected: `err` pulses and the block stays in IDLE.
  - `start` while `busy` is ignored and produces no `err`.
- State sequence: IDLE → WFILL → LOAD → GAP → AFILL → EXEC → DRAIN → DONE → IDLE. A phase counter resets on every state entry.
- WFILL, COL+1 cycles, c=0..COL:
  - CEN_xmem=(c==COL), WEN_xmem=1.
  - A_xmem=W_BASE+min(c,COL-1).
  - l0_wr=(c>=1).
- LOAD, COL+ROW cycles: load=1, l0_rd=1.
- GAP, GAP_CYC cycles: idle word.
- AFILL, LEN_NIJ+1 cycles: same pattern as WFILL with base 0 and LEN_NIJ words.
- EXEC, ROW+COL+LEN_NIJ cycles: execute=1, l0_rd=1.
- DRAIN:
  - bypass=1 throughout.
  - ofifo_rd=1 while `ofifo_valid && rd_cnt<LEN_ONIJ`.
  - Each issued read schedules a PMEM write RD2WR_LAT cycles later, via a shift register of depth RD2WR_LAT.
  - Each write drives CEN_pmem=0, WEN_pmem=0, A_pmem=kij*LEN_ONIJ+wr_cnt.
  - Exit DRAIN when wr_cnt==LEN_ONIJ.
- DONE, 1 cycle: idle word, `done`=1.
- Counters: rd_cnt and wr_cnt are 5 bits and saturate at LEN_ONIJ. A_pmem is computed at 11 bits; the maximum is 8*16+15=143, so it never wraps.
- Reset mid-pass: all state, counters and outputs take reset values immediately. No partial PMEM write may follow deassertion.

## Timing
- Reset values: `inst`=36'h1_800C_0000, `busy`=0, `done`=0, `err`=0.
- The `inst` for the first WFILL cycle is loaded on the same edge that samples an accepted `start`. `busy` rises on that same edge.
- Cycle count with defaults and `ofifo_valid` held high:
  - Fill, load, gap and execute phases take 125 cycles.
  - Reads are issued on edges 125–140 after start.
  - Writes are issued on edges 127–142.
  - `done` is loaded on edge 143.
- If `ofifo_valid` is low, ofifo_rd is withheld and rd_cnt holds. Pending writes still retire on schedule.
- `err` is high for exactly the cycle after the offending `start`.

## Structure
- Package `core_ctrl_pkg`:
  - Bit-position constants for every `inst` field.
  - `INST_IDLE` constant.
  - State enum.
- Sub-module `core_ctrl_drain` holds rd_cnt, wr_cnt, the RD2WR_LAT shift register and the PMEM address. It takes kij and an enable, and returns the ofifo_rd, pmem fields and a finished flag.

## Test plan
- Reset asserted mid-EXEC, then released:
  - `inst`=36'h1_800C_0000 immediately.
  - `busy`=0.
  - No write in the following 20 cycles.
- `start`, kij=0, `ofifo_valid`=1:
  - A_xmem walks 0x400..0x407 and l0_wr is high for 8 cycles.
  - load high for 16 cycles, execute high for 52 cycles.
  - PMEM writes to addresses 0..15.
  - `done` on edge 143.
- `start`, kij=8: writes to A_pmem 128..143 with bypass=1 throughout DRAIN.
- `start`, kij=9: `err` pulses once, `busy` stays 0, `inst` stays idle.
- `ofifo_valid` low for 5 cycles mid-DRAIN:
  - Exactly 16 reads and 16 writes are issued.
  - Write addresses are contiguous.
  - `done` is delayed by 5 cycles.
- `start` pulsed during LOAD: no effect on the sequence and no `err`.
